// File: rtl/mo_line_buffer.sv
// mo_line_buffer: double-buffered motion-object line buffer.
// One bank fills with shifter pixels for the next line while the other replays the
// current line to graphic priority and is cleared as it is read. Banks swap on LINE_SWAP.
// Build option: define MO_PRIORITY_EN for first-written-object-wins overlap;
// by default the last opaque pixel written to a location wins.
module mo_line_buffer #(
  parameter int unsigned LINE_W = 336,
  parameter int unsigned AW     = 9,
  parameter int unsigned PIX_W  = 8
) (
  input  logic             MCKR,
  input  logic             RESET_b,
  input  logic             PIXEN,
  input  logic             LINE_SWAP,
  input  logic             BUFCLR_b,
  input  logic             HLD,
  input  logic [AW-1:0]    HPOS,
  input  logic             MOSR_VLD,
  input  logic [PIX_W-1:0] MOSR,
  input  logic             MATCH_b,
  output logic [PIX_W-1:0] MPX,
  output logic             PADB,
  output logic             INIT_BUSY
);

  localparam logic [0:0]       ST_INIT = 1'b0;
  localparam logic [0:0]       ST_RUN  = 1'b1;
  localparam logic [AW:0]      LW      = (AW+1)'(LINE_W);
  localparam logic [AW-1:0]    LAST    = AW'(LINE_W - 1);
  localparam logic [PIX_W-1:0] EMPTY   = '1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [AW-1:0]    r_init_addr;
  logic             r_init_busy;
  logic             r_padb;
  logic [AW-1:0]    r_rd_addr;
  logic [AW-1:0]    r_wr_pos;
  logic [PIX_W-1:0] r_mpx;
  logic             r_pend_vld;
  logic             r_pend_bank;
  logic [AW-1:0]    r_pend_addr;
  logic [PIX_W-1:0] r_pend_data;
  logic [PIX_W-1:0] r_mem [0:1][0:LINE_W-1];

  logic          w_run;
  logic          w_disp_bank;
  logic          w_rd_ok;
  logic          w_rd_en;
  logic          w_clr;
  logic          w_accept;
  logic [AW-1:0] w_wr_addr;
  logic          w_opaque;
  logic          w_wr_ok;
  logic          w_pend_load;
  logic          w_commit;

  // Bank 0 is A, bank 1 is B; PADB names the display bank as A when high.
  assign w_run       = (r_state == ST_RUN);
  assign w_disp_bank = ~r_padb;
  assign w_rd_ok     = ({1'b0, r_rd_addr} < LW);
  assign w_rd_en     = w_run & PIXEN & w_rd_ok;
  assign w_clr       = w_rd_en & ~BUFCLR_b;
  assign w_accept    = w_run & MOSR_VLD & ~MATCH_b;
  assign w_wr_addr   = HLD ? HPOS : r_wr_pos;
  assign w_opaque    = (MOSR[3:0] != 4'hF);
  assign w_wr_ok     = ({1'b0, w_wr_addr} < LW);
  assign w_pend_load = w_accept & w_opaque & w_wr_ok;

`ifdef MO_PRIORITY_EN
  logic [PIX_W-1:0] w_stored;
  // The previous pending write has already landed, so the RAM holds the current owner.
  assign w_stored = r_mem[r_pend_bank][r_pend_addr];
  assign w_commit = r_pend_vld & (w_stored[3:0] == 4'hF);
`else
  assign w_commit = r_pend_vld;
`endif

  // State register.
  always_ff @(posedge MCKR) begin
    if (!RESET_b) r_state <= ST_INIT;
    else          r_state <= w_state_nxt;
  end

  // Next state: leave the clear sweep after the last visible address.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_init_addr == LAST) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Sweep counter, display read pointer, fill position, pending write and bank select.
  always_ff @(posedge MCKR) begin
    if (!RESET_b) begin
      r_init_addr <= '0;
      r_init_busy <= 1'b1;
      r_padb      <= 1'b0;
      r_rd_addr   <= '0;
      r_wr_pos    <= '0;
      r_mpx       <= EMPTY;
      r_pend_vld  <= 1'b0;
      r_pend_bank <= 1'b0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
    end else begin
      if (r_state == ST_INIT) begin
        r_init_addr <= r_init_addr + AW'(1);
        if (r_init_addr == LAST) r_init_busy <= 1'b0;
      end
      if (w_run && PIXEN) begin
        if (w_rd_ok) begin
          r_mpx     <= r_mem[w_disp_bank][r_rd_addr];
          r_rd_addr <= r_rd_addr + AW'(1);
        end else begin
          r_mpx <= EMPTY;
        end
      end
      if (w_accept)         r_wr_pos <= w_wr_addr + AW'(1);
      else if (w_run && HLD) r_wr_pos <= HPOS;
      r_pend_vld <= w_pend_load;
      if (w_pend_load) begin
        r_pend_bank <= r_padb;
        r_pend_addr <= w_wr_addr;
        r_pend_data <= MOSR;
      end
      if (w_run && LINE_SWAP) begin
        r_padb    <= ~r_padb;
        r_rd_addr <= '0;
      end
    end
  end

  // Line RAM: sweep both banks, clear-after-read on display, pending write on fill.
  always_ff @(posedge MCKR) begin
    if (RESET_b) begin
      if (r_state == ST_INIT) begin
        r_mem[0][r_init_addr] <= EMPTY;
        r_mem[1][r_init_addr] <= EMPTY;
      end else begin
        if (w_clr)    r_mem[w_disp_bank][r_rd_addr] <= EMPTY;
        if (w_commit) r_mem[r_pend_bank][r_pend_addr] <= r_pend_data;
      end
    end
  end

  assign MPX       = r_mpx;
  assign PADB      = r_padb;
  assign INIT_BUSY = r_init_busy;

endmodule

// File: tb/tb_mo_line_buffer.sv
// tb_mo_line_buffer: directed and randomized bench for mo_line_buffer against a
// line-level model (one fill line, one display line, exchanged on swap).
module tb_mo_line_buffer;

  localparam int LINE_W = 336;

  logic       clk;
  logic       rst_b;
  logic       pixen;
  logic       swap;
  logic       bufclr_b;
  logic       hld;
  logic [8:0] hpos;
  logic       vld;
  logic [7:0] mosr;
  logic       match_b;
  logic [7:0] MPX;
  logic       PADB;
  logic       INIT_BUSY;

  mo_line_buffer dut (
    .MCKR      (clk),
    .RESET_b   (rst_b),
    .PIXEN     (pixen),
    .LINE_SWAP (swap),
    .BUFCLR_b  (bufclr_b),
    .HLD       (hld),
    .HPOS      (hpos),
    .MOSR_VLD  (vld),
    .MOSR      (mosr),
    .MATCH_b   (match_b),
    .MPX       (MPX),
    .PADB      (PADB),
    .INIT_BUSY (INIT_BUSY)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_fill [LINE_W];
  logic [7:0] m_disp [LINE_W];
  logic [7:0] line_rd [LINE_W];
  logic [7:0] m_mpx;
  logic       m_padb;
  logic       m_busy;
  int         m_remain;
  int         m_rd;
  int         m_wr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one clock edge's worth of behaviour to the model using the driven inputs.
  task automatic model_edge();
    int a;
    logic [7:0] t;
    if (!rst_b) begin
      m_busy = 1'b1; m_remain = LINE_W; m_mpx = 8'hFF; m_padb = 1'b0; m_rd = 0; m_wr = 0;
      for (int i = 0; i < LINE_W; i++) begin m_fill[i] = 8'hFF; m_disp[i] = 8'hFF; end
    end else if (m_busy) begin
      m_remain--;
      if (m_remain == 0) m_busy = 1'b0;
    end else begin
      if (pixen) begin
        if (m_rd < LINE_W) begin
          m_mpx = m_disp[m_rd];
          if (!bufclr_b) m_disp[m_rd] = 8'hFF;
          m_rd++;
        end else begin
          m_mpx = 8'hFF;
        end
      end
      if (vld && !match_b) begin
        a = hld ? int'(hpos) : m_wr;
        if (a < LINE_W && mosr[3:0] != 4'hF) begin
`ifdef MO_PRIORITY_EN
          if (m_fill[a][3:0] == 4'hF) m_fill[a] = mosr;
`else
          m_fill[a] = mosr;
`endif
        end
        m_wr = (a + 1) % 512;
      end else if (hld) begin
        m_wr = int'(hpos);
      end
      if (swap) begin
        m_padb = ~m_padb;
        m_rd = 0;
        for (int i = 0; i < LINE_W; i++) begin
          t = m_fill[i]; m_fill[i] = m_disp[i]; m_disp[i] = t;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("mpx", 32'(MPX), 32'(m_mpx));
    check("padb", 32'(PADB), 32'(m_padb));
    check("init_busy", 32'(INIT_BUSY), 32'(m_busy));
  endtask

  task automatic swap_step();
    swap = 1'b1;
    step();
    swap = 1'b0;
  endtask

  task automatic read_line(input logic bclr);
    pixen = 1'b1; bufclr_b = bclr;
    for (int i = 0; i < LINE_W; i++) begin
      step();
      line_rd[i] = MPX;
    end
    step();
    pixen = 1'b0; bufclr_b = 1'b0;
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (INIT_BUSY === 1'b1 && n < 2000) begin
      n++;
      step();
    end
    check("init_len", 32'(n), 32'(LINE_W));
  endtask

  task automatic count_non_ff(input string tag);
    int n;
    n = 0;
    for (int i = 0; i < LINE_W; i++) if (line_rd[i] !== 8'hFF) n++;
    check(tag, 32'(n), 32'd0);
  endtask

  task automatic put(input logic h, input logic [8:0] p, input logic [7:0] d);
    hld = h; hpos = p; vld = 1'b1; match_b = 1'b0; mosr = d;
    step();
    hld = 1'b0; vld = 1'b0; match_b = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_ovl;
    rst_b = 1'b0; pixen = 1'b0; swap = 1'b0; bufclr_b = 1'b0; hld = 1'b0;
    hpos = '0; vld = 1'b0; mosr = '0; match_b = 1'b1;
    m_mpx = 8'hFF; m_padb = 1'b0; m_busy = 1'b1; m_remain = LINE_W; m_rd = 0; m_wr = 0;

    // Reset and sweep
    step(); step();
    rst_b = 1'b1;
    wait_init();
    check("padb_after_init", 32'(PADB), 32'd0);
    swap_step();
    read_line(1'b0);
    count_non_ff("idle_line");

    // Write path with a transparent pixel in the middle
    hld = 1'b1; hpos = 9'd10; step(); hld = 1'b0;
    vld = 1'b1; match_b = 1'b0;
    mosr = 8'h21; step();
    mosr = 8'h3F; step();
    mosr = 8'h45; step();
    vld = 1'b0; match_b = 1'b1;
    swap_step();
    read_line(1'b1);
    check("wr_addr9", 32'(line_rd[9]), 32'hFF);
    check("wr_addr10", 32'(line_rd[10]), 32'h21);
    check("wr_addr11", 32'(line_rd[11]), 32'hFF);
    check("wr_addr12", 32'(line_rd[12]), 32'h45);
    check("wr_addr13", 32'(line_rd[13]), 32'hFF);

    // Frozen line reappears, then clear-after-read empties it
    swap_step(); swap_step();
    read_line(1'b0);
    check("freeze_addr10", 32'(line_rd[10]), 32'h21);
    check("freeze_addr12", 32'(line_rd[12]), 32'h45);
    swap_step(); swap_step();
    read_line(1'b0);
    count_non_ff("cleared_line");

    // Right-edge drop, no wrap
    put(1'b1, 9'd334, 8'h11);
    put(1'b0, 9'd0, 8'h12);
    put(1'b0, 9'd0, 8'h13);
    put(1'b0, 9'd0, 8'h14);
    swap_step();
    read_line(1'b0);
    check("edge_334", 32'(line_rd[334]), 32'h11);
    check("edge_335", 32'(line_rd[335]), 32'h12);
    check("edge_0", 32'(line_rd[0]), 32'hFF);
    check("edge_1", 32'(line_rd[1]), 32'hFF);

    // Overlapping objects at the same position
    hld = 1'b1; hpos = 9'd20; vld = 1'b1; match_b = 1'b0;
    mosr = 8'h52; step();
    mosr = 8'h73; step();
    hld = 1'b0; vld = 1'b0; match_b = 1'b1;
    swap_step();
    read_line(1'b0);
`ifdef MO_PRIORITY_EN
    exp_ovl = 8'h52;
`else
    exp_ovl = 8'h73;
`endif
    check("overlap_20", 32'(line_rd[20]), 32'(exp_ovl));

    // Swap immediately after an accept
    put(1'b1, 9'd5, 8'h66);
    swap_step();
    read_line(1'b1);
    check("late_write_5", 32'(line_rd[5]), 32'h66);

    // Reset in the middle of a displayed line
    swap_step(); swap_step();
    pixen = 1'b1; bufclr_b = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("pre_reset_mpx", 32'(MPX), 32'h66);
    rst_b = 1'b0;
    step();
    check("reset_mpx", 32'(MPX), 32'hFF);
    check("reset_busy", 32'(INIT_BUSY), 32'd1);
    rst_b = 1'b1; pixen = 1'b0; bufclr_b = 1'b0;
    wait_init();

    // Randomized lines
    for (int ln = 0; ln < 6; ln++) begin
      for (int c = 0; c < 380; c++) begin
        pixen    = ($urandom_range(0, 3) != 0);
        bufclr_b = ($urandom_range(0, 2) == 0);
        hld      = ($urandom_range(0, 15) == 0);
        hpos     = 9'($urandom_range(0, 400));
        vld      = ($urandom_range(0, 3) != 0);
        match_b  = ($urandom_range(0, 3) == 0);
        mosr     = 8'($urandom);
        if ($urandom_range(0, 3) == 0) mosr[3:0] = 4'hF;
        step();
      end
      vld = 1'b0; hld = 1'b0;
      swap_step();
    end
    pixen = 1'b0;
    read_line(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
